// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: time-shares one external combinational W x W multiplier
// among NREQ requesters. Round-robin arbitration in IDLE, one cycle of
// multiplier evaluation on registered operands (CALC), then the registered
// product is held in RESP until the consumer takes it.
// Optional build macro MUL_SHARE_STATS_EN adds saturating counters for
// completed operations (stat_ops) and stalled response cycles (stat_stall).
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2,
    parameter int W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic [2*W-1:0]    mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_p,
    output logic [ID_W-1:0]   rsp_id
`ifdef MUL_SHARE_STATS_EN
    ,
    output logic [31:0]       stat_ops,
    output logic [31:0]       stat_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   tag_reg;
    logic [W-1:0]      mul_x_reg;
    logic [W-1:0]      mul_y_reg;
    logic [2*W-1:0]    rsp_p_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic              rsp_valid_reg;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              req_fire;
    logic              rsp_fire;

    logic [W-1:0]      x_arr [NREQ];
    logic [W-1:0]      y_arr [NREQ];

    // Unpack the flat operand buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*W +: W];
            assign y_arr[gi] = req_y[gi*W +: W];
        end
    endgenerate

    // Round-robin search: first valid index above the last winner, then wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i > int'(rr_ptr_reg))) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i <= int'(rr_ptr_reg))) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end

    // Grant is offered only while idle, and never while reset is held.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == S_IDLE) && !rst && grant_found &&
                                   (grant_idx == ID_W'(gi));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake strobes.
    always_comb begin
        state_next = state_reg;
        req_fire   = 1'b0;
        rsp_fire   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (grant_found) begin
                    req_fire   = 1'b1;
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand stage: capture the winner's operands; they are left in place
    // afterwards so the multiplier inputs do not toggle between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x_reg  <= '0;
            mul_y_reg  <= '0;
            tag_reg    <= '0;
            rr_ptr_reg <= ID_W'(NREQ - 1);
        end else if (req_fire) begin
            mul_x_reg  <= x_arr[grant_idx];
            mul_y_reg  <= y_arr[grant_idx];
            tag_reg    <= grant_idx;
            rr_ptr_reg <= grant_idx;
        end
    end

    // Product stage: sample the multiplier after its single evaluation cycle,
    // then hold until the consumer handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_p_reg     <= '0;
            rsp_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
        end else if (state_reg == S_CALC) begin
            rsp_p_reg     <= mul_p;
            rsp_id_reg    <= tag_reg;
            rsp_valid_reg <= 1'b1;
        end else if (rsp_fire) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign mul_x     = mul_x_reg;
    assign mul_y     = mul_y_reg;
    assign rsp_p     = rsp_p_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_valid = rsp_valid_reg;

`ifdef MUL_SHARE_STATS_EN
    logic [31:0] stat_ops_reg;
    logic [31:0] stat_stall_reg;

    // Saturating activity counters: completed responses and stalled RESP cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_reg   <= '0;
            stat_stall_reg <= '0;
        end else begin
            if (rsp_fire && (stat_ops_reg != 32'hFFFF_FFFF)) begin
                stat_ops_reg <= stat_ops_reg + 32'd1;
            end
            if ((state_reg == S_RESP) && !rsp_ready && (stat_stall_reg != 32'hFFFF_FFFF)) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
        end
    end

    assign stat_ops   = stat_ops_reg;
    assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter: exact signed multiplier stub, directed
// scenarios plus a randomized run checked against a transaction-level model
// (round-robin winner, signed product, fixed two-cycle response latency).
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_p;
    logic [ID_W-1:0]   rsp_id;
`ifdef MUL_SHARE_STATS_EN
    logic [31:0]       stat_ops;
    logic [31:0]       stat_stall;
`endif

    always #5 clk = ~clk;

    // Exact signed multiplier stub.
    logic signed [2*W-1:0] stub_x;
    logic signed [2*W-1:0] stub_y;
    assign stub_x = {{W{mul_x[W-1]}}, mul_x};
    assign stub_y = {{W{mul_y[W-1]}}, mul_y};
    assign mul_p  = stub_x * stub_y;

    mul_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
`ifdef MUL_SHARE_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level reference model.
    int              last_g;
    bit              busy;
    int              age;        // 1: evaluation cycle, 2: response offered
    logic [2*W-1:0]  exp_p;
    logic [ID_W-1:0] exp_id;
    logic [W-1:0]    last_x;
    logic [W-1:0]    last_y;
    bit              evaluated;
    int              acc;
    int              prev_acc;
    logic [NREQ-1:0] exp_ready;
    bit              exp_valid;
    int              ops_cnt;
    int              stall_cnt;

    function automatic void model_reset();
        last_g    = NREQ - 1;
        busy      = 0;
        age       = 0;
        last_x    = '0;
        last_y    = '0;
        evaluated = 0;
        acc       = -1;
        prev_acc  = -1;
        ops_cnt   = 0;
        stall_cnt = 0;
    endfunction

    // Expected outputs for the current cycle given the driven inputs.
    function automatic void model_eval();
        acc       = -1;
        exp_ready = '0;
        exp_valid = busy && (age >= 2);
        if (!busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (last_g + k) % NREQ;
                if (acc < 0 && req_valid[idx]) acc = idx;
            end
        end
        if (acc >= 0) exp_ready[acc] = 1'b1;
        evaluated = 1;
    endfunction

    // Effect of the coming clock edge on the model.
    function automatic void model_advance();
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        int a;
        int b;
        prev_acc = -1;
        if (!evaluated) return;
        evaluated = 0;
        if (!busy) begin
            if (acc >= 0) begin
                sa       = req_x[acc*W +: W];
                sb       = req_y[acc*W +: W];
                a        = sa;
                b        = sb;
                exp_p    = a * b;
                exp_id   = ID_W'(acc);
                last_x   = req_x[acc*W +: W];
                last_y   = req_y[acc*W +: W];
                last_g   = acc;
                busy     = 1;
                age      = 1;
                prev_acc = acc;
            end
        end else if (age == 1) begin
            age = 2;
        end else if (rsp_ready) begin
            busy = 0;
            ops_cnt++;
        end else begin
            stall_cnt++;
        end
    endfunction

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic new_ops(input int i);
        logic [W-1:0] vx;
        logic [W-1:0] vy;
        vx = W'($urandom);
        vy = W'($urandom);
        case ($urandom % 6)
            0: vx = 16'h8000;
            1: vy = 16'h7FFF;
            2: vx = 16'hFFFF;
            3: vy = 16'h0000;
            default: ;
        endcase
        req_x[i*W +: W] = vx;
        req_y[i*W +: W] = vy;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b want 0000", req_ready);
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_p !== 32'd0 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_rsp: got valid=%b p=%h id=%0d want 0/0/0", rsp_valid, rsp_p, rsp_id);
        end
        vectors++;
        if (mul_x !== 16'd0 || mul_y !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_operands: got x=%h y=%h want 0/0", mul_x, mul_y);
        end
        rst       = 1'b0;
        req_valid = '0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_single_op(input int r, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [2*W-1:0] want_p);
        apply_reset();
        tick();
        req_valid          = NREQ'(1 << r);
        req_x[r*W +: W]    = x;
        req_y[r*W +: W]    = y;
        rsp_ready          = 1'b1;
        sample();
        vectors++;
        if (req_ready !== NREQ'(1 << r)) begin
            miscompares++;
            $display("FAIL single_grant: got %b want %b", req_ready, NREQ'(1 << r));
        end
        tick();
        req_valid = '0;
        sample();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latency_t1: got rsp_valid=%b want 0", rsp_valid);
        end
        vectors++;
        if (mul_x !== x || mul_y !== y) begin
            miscompares++;
            $display("FAIL single_operands: got x=%h y=%h want %h/%h", mul_x, mul_y, x, y);
        end
        tick();
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_p !== want_p || rsp_id !== ID_W'(r)) begin
            miscompares++;
            $display("FAIL single_resp: got valid=%b p=%h id=%0d want 1/%h/%0d",
                     rsp_valid, rsp_p, rsp_id, want_p, r);
        end
        tick();
        sample();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: got rsp_valid=%b want 0", rsp_valid);
        end
        $display("test_single_op r=%0d x=%h y=%h p=%h id=%0d", r, x, y, rsp_p, rsp_id);
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            tick();
            if (c == 0) begin
                req_valid = '1;
                for (int i = 0; i < NREQ; i++) new_ops(i);
            end else if (prev_acc >= 0) begin
                new_ops(prev_acc);
            end
            rsp_ready = 1'b1;
            sample();
            want = (c % 3 == 0) ? NREQ'(1 << ((c / 3) % NREQ)) : '0;
            vectors++;
            if (req_ready !== want) begin
                miscompares++;
                $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, want);
            end
            if (exp_valid) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_p !== exp_p || rsp_id !== exp_id) begin
                    miscompares++;
                    $display("FAIL rr_resp c=%0d: got valid=%b p=%h id=%0d want 1/%h/%0d",
                             c, rsp_valid, rsp_p, rsp_id, exp_p, exp_id);
                end
            end
        end
        req_valid = '0;
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] want_p;
        apply_reset();
        tick();
        req_valid = 4'b0010;
        new_ops(1);
        rsp_ready = 1'b0;
        sample();
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_grant: got %b want 0010", req_ready);
        end
        want_p = exp_ready[1] ? 32'(32'($signed(req_x[W +: W])) * 32'($signed(req_y[W +: W]))) : '0;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        sample();
        for (int s = 1; s <= 6; s++) begin
            tick();
            rsp_ready = (s == 6);
            sample();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_p !== want_p || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_hold s=%0d: got valid=%b p=%h id=%0d ready=%b want 1/%h/1/0000",
                         s, rsp_valid, rsp_p, rsp_id, req_ready, want_p);
            end
        end
        tick();
        rsp_ready = 1'b0;
        sample();
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_idle: got valid=%b ready=%b want 0/0100", rsp_valid, req_ready);
        end
        req_valid = '0;
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        tick();
        req_valid = 4'b0100;
        new_ops(2);
        rsp_ready = 1'b1;
        sample();
        tick();
        req_valid = '0;
        sample();
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_calc: got valid=%b ready=%b want 0/0000", rsp_valid, req_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_p !== 32'd0 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got valid=%b p=%h id=%0d want 0/0/0", rsp_valid, rsp_p, rsp_id);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        sample();
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_next_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        sample();
        tick();
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== exp_p) begin
            miscompares++;
            $display("FAIL midrst_resp: got valid=%b id=%0d p=%h want 1/0/%h", rsp_valid, rsp_id, rsp_p, exp_p);
        end
        $display("test_reset_mid_op done");
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            rsp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NREQ; i++) begin
                if (prev_acc == i) begin
                    req_valid[i] = 1'($urandom % 2);
                    new_ops(i);
                end else if (!req_valid[i]) begin
                    if ($urandom % 3 == 0) begin
                        req_valid[i] = 1'b1;
                        new_ops(i);
                    end
                end else if ($urandom % 16 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            sample();
            vectors++;
            if (req_ready !== exp_ready || rsp_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL rand_ctrl c=%0d: got ready=%b valid=%b want %b/%b",
                         c, req_ready, rsp_valid, exp_ready, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (rsp_p !== exp_p || rsp_id !== exp_id) begin
                    miscompares++;
                    $display("FAIL rand_resp c=%0d: got p=%h id=%0d want %h/%0d", c, rsp_p, rsp_id, exp_p, exp_id);
                end
            end
            vectors++;
            if (mul_x !== last_x || mul_y !== last_y) begin
                miscompares++;
                $display("FAIL rand_operands c=%0d: got x=%h y=%h want %h/%h", c, mul_x, mul_y, last_x, last_y);
            end
        end
        tick();
`ifdef MUL_SHARE_STATS_EN
        vectors++;
        if (stat_ops !== 32'(ops_cnt) || stat_stall !== 32'(stall_cnt)) begin
            miscompares++;
            $display("FAIL rand_stats: got ops=%0d stall=%0d want %0d/%0d", stat_ops, stat_stall, ops_cnt, stall_cnt);
        end
`endif
        $display("test_random ops=%0d stalls=%0d", ops_cnt, stall_cnt);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_op(0, 16'd3, 16'd5, 32'd15);
        test_single_op(2, 16'hFFFE, 16'h0007, 32'hFFFF_FFF2);
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
